// File: rtl/alu_seq_if.sv
// alu_seq handshake bundle: issue side (in_valid/in_ready, a, b, opcode)
// and writeback side (out_valid/out_ready, result, remainder, flags).
interface alu_seq_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [3:0]   opcode;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;
  logic [N-1:0] remainder;
  logic         carry_out;
  logic         zero;
  logic         overflow;
  logic         div_by_zero;
  logic         illegal;

  modport master (
    output in_valid, a, b, opcode, out_ready,
    input  in_ready, out_valid, result, remainder,
    input  carry_out, zero, overflow, div_by_zero, illegal
  );

  modport slave (
    input  in_valid, a, b, opcode, out_ready,
    output in_ready, out_valid, result, remainder,
    output carry_out, zero, overflow, div_by_zero, illegal
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: handshaked multi-cycle N-bit ALU, iterative MUL/DIV.
// Ports: clk, rst_n (async low), bus (alu_seq_if.slave). DIV needs ALU_SEQ_DIV_EN.
module alu_seq #(
  parameter int N = 32
) (
  input logic     clk,
  input logic     rst_n,
  alu_seq_if.slave bus
);
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [N-1:0]  MIN  = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic [N-1:0]  hi, lo, mag;
  logic          neg_r;
  logic          in_rdy, accept, go_busy;

  logic [N-1:0]  s_res, s_rem;
  logic          s_cy, s_ov, s_dz, s_ill;
  logic [N:0]    add_w, sub_w;
  logic [N-1:0]  abs_a, abs_b;

  logic [N:0]    mul_sum;
  logic [N-1:0]  hi_n, lo_n;
  logic [2*N-1:0] prod, prod_s;
  logic [N-1:0]  f_res, f_rem;
  logic          f_ov;

`ifdef ALU_SEQ_DIV_EN
  logic          is_div, sa_r, dov_r;
  logic [N:0]    div_r, div_d;
`endif

  assign abs_a = bus.a[N-1] ? -bus.a : bus.a;
  assign abs_b = bus.b[N-1] ? -bus.b : bus.b;

  // Single-cycle results, and whether the op needs the iterative path
  always_comb begin
    s_res   = '0;
    s_rem   = '0;
    s_cy    = 1'b0;
    s_ov    = 1'b0;
    s_dz    = 1'b0;
    s_ill   = 1'b0;
    go_busy = 1'b0;
    add_w   = {1'b0, bus.a} + {1'b0, bus.b};
    sub_w   = {1'b0, bus.a} - {1'b0, bus.b};
    unique case (bus.opcode)
      4'h0: s_res = bus.a & bus.b;
      4'h1: s_res = bus.a | bus.b;
      4'h2: s_res = bus.a ^ bus.b;
      4'h3: s_res = ~bus.a;
      4'h4: begin
        s_res = -bus.a;
        s_ov  = (bus.a == MIN);
      end
      4'h5: begin
        s_res = -bus.b;
        s_ov  = (bus.b == MIN);
      end
      4'h6: begin
        s_res = add_w[N-1:0];
        s_cy  = add_w[N];
        s_ov  = (bus.a[N-1] == bus.b[N-1])
             && (add_w[N-1] != bus.a[N-1]);
      end
      4'h7: begin
        s_res = sub_w[N-1:0];
        s_cy  = ~sub_w[N];
        s_ov  = (bus.a[N-1] != bus.b[N-1])
             && (sub_w[N-1] != bus.a[N-1]);
      end
      4'h8: go_busy = 1'b1;
`ifdef ALU_SEQ_DIV_EN
      4'h9: begin
        if (bus.b == '0) begin
          s_res = '1;
          s_rem = bus.a;
          s_dz  = 1'b1;
        end else begin
          go_busy = 1'b1;
        end
      end
`endif
      default: s_ill = 1'b1;
    endcase
  end

  // One iteration: shift-add on {hi,lo} for MUL, restoring step for DIV
  always_comb begin
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, mag} : '0);
    hi_n    = mul_sum[N:1];
    lo_n    = {mul_sum[0], lo[N-1:1]};
`ifdef ALU_SEQ_DIV_EN
    div_r   = {hi, lo[N-1]};
    div_d   = div_r - {1'b0, mag};
    if (is_div) begin
      if (div_d[N]) begin
        hi_n = div_r[N-1:0];
        lo_n = {lo[N-2:0], 1'b0};
      end else begin
        hi_n = div_d[N-1:0];
        lo_n = {lo[N-2:0], 1'b1};
      end
    end
`endif
  end

  // Apply signs after the final iteration
  always_comb begin
    prod   = {hi_n, lo_n};
    prod_s = neg_r ? -prod : prod;
    f_res  = prod_s[N-1:0];
    f_rem  = '0;
    f_ov   = !((&prod_s[2*N-1:N-1]) || !(|prod_s[2*N-1:N-1]));
`ifdef ALU_SEQ_DIV_EN
    if (is_div) begin
      f_res = neg_r ? -lo_n : lo_n;
      f_rem = sa_r ? -hi_n : hi_n;
      f_ov  = dov_r;
    end
`endif
  end

  always_comb begin
    in_rdy  = rst_n && ((state == IDLE)
           || (state == DONE && bus.out_ready));
    accept  = bus.in_valid && in_rdy;
    state_n = state;
    unique case (1'b1)
      accept:
        state_n = go_busy ? BUSY : DONE;
      (state == BUSY && cnt == LAST):
        state_n = DONE;
      (state == DONE && bus.out_ready && !accept):
        state_n = IDLE;
      default: ;
    endcase
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      hi              <= '0;
      lo              <= '0;
      mag             <= '0;
      neg_r           <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      is_div          <= 1'b0;
      sa_r            <= 1'b0;
      dov_r           <= 1'b0;
`endif
      bus.result      <= '0;
      bus.remainder   <= '0;
      bus.carry_out   <= 1'b0;
      bus.zero        <= 1'b0;
      bus.overflow    <= 1'b0;
      bus.div_by_zero <= 1'b0;
      bus.illegal     <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        cnt   <= '0;
        hi    <= '0;
        neg_r <= bus.a[N-1] ^ bus.b[N-1];
        lo    <= abs_b;
        mag   <= abs_a;
`ifdef ALU_SEQ_DIV_EN
        is_div <= (bus.opcode == 4'h9);
        sa_r   <= bus.a[N-1];
        dov_r  <= (bus.a == MIN) && (bus.b == '1);
        if (bus.opcode == 4'h9) begin
          lo  <= abs_a;
          mag <= abs_b;
        end
`endif
        if (!go_busy) begin
          bus.result      <= s_res;
          bus.remainder   <= s_rem;
          bus.carry_out   <= s_cy;
          bus.zero        <= (s_res == '0);
          bus.overflow    <= s_ov;
          bus.div_by_zero <= s_dz;
          bus.illegal     <= s_ill;
        end
      end else if (state == BUSY) begin
        cnt <= cnt + 1'b1;
        hi  <= hi_n;
        lo  <= lo_n;
        if (cnt == LAST) begin
          bus.result      <= f_res;
          bus.remainder   <= f_rem;
          bus.carry_out   <= 1'b0;
          bus.zero        <= (f_res == '0);
          bus.overflow    <= f_ov;
          bus.div_by_zero <= 1'b0;
          bus.illegal     <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq (N=32).
// Covers reset, flags, MUL/DIV latency, backpressure, streaming, abort.
module tb_alu_seq;
  localparam int N = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   lat;

  alu_seq_if #(.N(N)) bus ();

  alu_seq #(.N(N)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op from IDLE, scramble inputs after accept, count latency
  task automatic run(input logic [3:0] op,
                     input logic [N-1:0] x,
                     input logic [N-1:0] y,
                     output int l);
    bus.opcode    = op;
    bus.a         = x;
    bus.b         = y;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = $urandom;
    bus.b        = $urandom;
    bus.opcode   = 4'($urandom);
    l = 1;
    while (!bus.out_valid && l < 100) begin
      @(posedge clk);
      #1;
      l++;
    end
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.opcode    = '0;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_illegal", bus.illegal, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1);

    run(4'h6, 32'h7FFF_FFFF, 32'h1, lat);
    chk("add_ovf_lat", lat, 1);
    chk("add_ovf_res", bus.result, 32'h8000_0000);
    chk("add_ovf_ov", bus.overflow, 1);
    chk("add_ovf_cy", bus.carry_out, 0);
    chk("busy_in_ready_done", bus.in_ready, 0);
    drain();

    run(4'h6, 32'hFFFF_FFFF, 32'h1, lat);
    chk("add_wrap_res", bus.result, 0);
    chk("add_wrap_cy", bus.carry_out, 1);
    chk("add_wrap_zero", bus.zero, 1);
    chk("add_wrap_ov", bus.overflow, 0);
    drain();

    run(4'h7, 32'd5, 32'd5, lat);
    chk("sub_eq_zero", bus.zero, 1);
    chk("sub_eq_cy", bus.carry_out, 1);
    drain();

    run(4'h7, 32'd3, 32'd5, lat);
    chk("sub_lt_res", bus.result, 32'hFFFF_FFFE);
    chk("sub_lt_cy", bus.carry_out, 0);
    chk("sub_lt_ov", bus.overflow, 0);
    drain();

    run(4'h4, 32'h8000_0000, 32'd0, lat);
    chk("nega_min_res", bus.result, 32'h8000_0000);
    chk("nega_min_ov", bus.overflow, 1);
    drain();

    run(4'h5, 32'd0, 32'd5, lat);
    chk("negb_res", bus.result, 32'hFFFF_FFFB);
    chk("negb_ov", bus.overflow, 0);
    drain();

    run(4'h3, 32'd0, 32'd0, lat);
    chk("not_res", bus.result, 32'hFFFF_FFFF);
    drain();

    run(4'h1, 32'h0000_00F0, 32'h0000_0F00, lat);
    chk("or_res", bus.result, 32'h0000_0FF0);
    drain();

    run(4'h8, -32'sd3, 32'd7, lat);
    chk("mul_neg_lat", lat, 33);
    chk("mul_neg_res", bus.result, 32'hFFFF_FFEB);
    chk("mul_neg_ov", bus.overflow, 0);
    drain();

    run(4'h8, 32'h0001_0000, 32'h0001_0000, lat);
    chk("mul_big_res", bus.result, 0);
    chk("mul_big_ov", bus.overflow, 1);
    chk("mul_big_zero", bus.zero, 1);
    drain();

    run(4'h8, 32'h8000_0000, 32'd1, lat);
    chk("mul_min_res", bus.result, 32'h8000_0000);
    chk("mul_min_ov", bus.overflow, 0);
    drain();

    run(4'hC, 32'd7, 32'd9, lat);
    chk("ill_lat", lat, 1);
    chk("ill_flag", bus.illegal, 1);
    chk("ill_res", bus.result, 0);
    drain();

`ifdef ALU_SEQ_DIV_EN
    run(4'h9, -32'sd7, 32'd2, lat);
    chk("div_lat", lat, 33);
    chk("div_res", bus.result, 32'hFFFF_FFFD);
    chk("div_rem", bus.remainder, 32'hFFFF_FFFF);
    drain();

    run(4'h9, 32'd9, 32'd0, lat);
    chk("div0_lat", lat, 1);
    chk("div0_res", bus.result, 32'hFFFF_FFFF);
    chk("div0_rem", bus.remainder, 32'd9);
    chk("div0_flag", bus.div_by_zero, 1);
    drain();

    run(4'h9, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    chk("divmin_ov", bus.overflow, 1);
    chk("divmin_res", bus.result, 32'h8000_0000);
    chk("divmin_rem", bus.remainder, 0);
    drain();
`else
    run(4'h9, 32'd9, 32'd3, lat);
    chk("nodiv_lat", lat, 1);
    chk("nodiv_ill", bus.illegal, 1);
    chk("nodiv_res", bus.result, 0);
    drain();
`endif

    run(4'h2, 32'h0000_F0F0, 32'h0000_0FF0, lat);
    for (int i = 0; i < 4; i++) begin
      chk("bp_valid", bus.out_valid, 1);
      chk("bp_res", bus.result, 32'h0000_FF00);
      chk("bp_in_ready", bus.in_ready, 0);
      @(posedge clk);
      #1;
    end

    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.opcode    = 4'h0;
    bus.a = 32'hFF00_FF00; bus.b = 32'h0F0F_0F0F;
    @(posedge clk);
    #1;
    chk("st0_valid", bus.out_valid, 1);
    chk("st0_res", bus.result, 32'h0F00_0F00);
    bus.a = 32'h1234_5678; bus.b = 32'hFFFF_0000;
    @(posedge clk);
    #1;
    chk("st1_valid", bus.out_valid, 1);
    chk("st1_res", bus.result, 32'h1234_0000);
    bus.a = 32'hAAAA_AAAA; bus.b = 32'h6666_6666;
    @(posedge clk);
    #1;
    chk("st2_valid", bus.out_valid, 1);
    chk("st2_res", bus.result, 32'h2222_2222);
    chk("st2_in_ready", bus.in_ready, 1);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("st_idle_valid", bus.out_valid, 0);
    bus.out_ready = 1'b0;

    bus.opcode   = 4'h8;
    bus.a        = 32'd3;
    bus.b        = 32'd4;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("busy_in_ready", bus.in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("abort_res", bus.result, 0);
    chk("abort_valid", bus.out_valid, 0);
    chk("abort_ov", bus.overflow, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("abort_in_ready", bus.in_ready, 1);
    run(4'h6, 32'd1, 32'd1, lat);
    chk("abort_add_lat", lat, 1);
    chk("abort_add_res", bus.result, 32'd2);
    drain();
    chk("abort_add_gone", bus.out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
